and_pipe_arbiter: RTL and testbench

- Round-robin arbiter that shares one two-stage registered AND datapath among N requesters.
- Each requester presents operand pairs (a, b); the winner's operands enter stage 1 (ab = a & b), and stage 2 registers the result to q.
- Results leave tagged with the requester index, at a fixed latency, with a pipeline-wide hold for back-pressure.

---
 rtl/and_pipe_arbiter.sv | 88 ++++++++
 tb/tb_and_pipe_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/and_pipe_arbiter.sv
// Round-robin arbiter in front of a two-stage registered AND datapath.
// Results leave tagged with the requester index; hold freezes the whole pipe.
module and_pipe_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_bus,
  input  logic [N*W-1:0] b_bus,
  input  logic           hold,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic [IDW-1:0] q_id,
  output logic           busy
);

  logic [IDW-1:0] r_ptr;
  logic           r_v1;
  logic [W-1:0]   r_ab;
  logic [IDW-1:0] r_id1;
  logic [W-1:0]   r_q;
  logic           r_q_valid;
  logic [IDW-1:0] r_q_id;

  logic           w_found;
  logic           w_take;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_ptr_next;
  logic [W-1:0]   w_a_sel;
  logic [W-1:0]   w_b_sel;

  // Rotating search starting at r_ptr; the first active request wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_idx   = IDW'(j);
      end
    end
  end

  // reset and hold both suppress the grant; gnt never sees the operand buses.
  assign w_take = w_found && !hold && !reset;
  assign gnt    = w_take ? (N'(1) << w_idx) : '0;

  assign w_ptr_next = (w_idx == IDW'(N - 1)) ? '0 : w_idx + 1'b1;
  assign w_a_sel    = a_bus[w_idx*W +: W];
  assign w_b_sel    = b_bus[w_idx*W +: W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_v1      <= 1'b0;
      r_ab      <= '0;
      r_id1     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_q_id    <= '0;
    end else if (!hold) begin
      if (w_take) begin
        r_ab  <= w_a_sel & w_b_sel;
        r_id1 <= w_idx;
        r_v1  <= 1'b1;
        r_ptr <= w_ptr_next;
      end else begin
        r_v1  <= 1'b0;
      end
      r_q       <= r_ab;
      r_q_id    <= r_id1;
      r_q_valid <= r_v1;
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign q_id    = r_q_id;
  assign busy    = r_v1 | r_q_valid;

endmodule

// File: tb/tb_and_pipe_arbiter.sv
// Directed bench for and_pipe_arbiter: reset, latency, round-robin, wrap, hold
// and mid-flight reset, with hand-computed expectations.
module tb_and_pipe_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IDW = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus;
  logic [N*W-1:0] b_bus;
  logic           hold;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [IDW-1:0] q_id;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  and_pipe_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .hold(hold), .gnt(gnt), .q(q), .q_valid(q_valid), .q_id(q_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask

  task automatic chk_q(input string tag, input logic [W-1:0] eq, input logic [IDW-1:0] eid);
    chk({tag, "_qv"}, 32'(q_valid), 32'd1);
    chk({tag, "_q"},  32'(q), 32'(eq));
    chk({tag, "_id"}, 32'(q_id), 32'(eid));
  endtask

  initial begin
    reset = 1'b1; req = 4'b1111; hold = 1'b0; a_bus = '0; b_bus = '0;
    #1;
    // Reset held for three edges with every request active.
    chk("rst_gnt0", 32'(gnt), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
    end
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_qid", 32'(q_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Round robin: a_i=FF, b_i=i+1, all requesting.
    for (int i = 0; i < N; i++) set_op(i, 8'hFF, 8'(i + 1));
    reset = 1'b0;
    #1;
    chk("rr_g0", 32'(gnt), 32'b0001);
    tick();
    chk("rr_g1", 32'(gnt), 32'b0010);
    chk("rr_qv_lat", 32'(q_valid), 32'h0);
    chk("rr_busy", 32'(busy), 32'h1);
    tick();
    chk("rr_g2", 32'(gnt), 32'b0100);
    chk_q("rr_r0", 8'h01, 2'd0);
    tick();
    chk("rr_g3", 32'(gnt), 32'b1000);
    chk_q("rr_r1", 8'h02, 2'd1);
    tick();
    chk("rr_g4", 32'(gnt), 32'b0001);
    chk_q("rr_r2", 8'h03, 2'd2);
    tick();
    req = 4'b0000;
    #1;
    chk("rr_idle_gnt", 32'(gnt), 32'h0);
    chk_q("rr_r3", 8'h04, 2'd3);
    tick();
    chk_q("rr_r4", 8'h01, 2'd0);
    tick();
    chk("rr_drain_qv", 32'(q_valid), 32'h0);
    chk("rr_drain_busy", 32'(busy), 32'h0);

    // Single requester latency; ptr is 1, requester 2 alone.
    set_op(2, 8'hF0, 8'h3C);
    req = 4'b0100;
    #1;
    chk("lat_gnt", 32'(gnt), 32'b0100);
    tick();
    req = 4'b0000;
    #1;
    chk("lat_gnt_off", 32'(gnt), 32'h0);
    chk("lat_qv_early", 32'(q_valid), 32'h0);
    chk("lat_busy", 32'(busy), 32'h1);
    tick();
    chk_q("lat_res", 8'h30, 2'd2);
    tick();
    chk("lat_qv_once", 32'(q_valid), 32'h0);

    // Wrap and skip: ptr=3, req=0101 -> 0 then 2.
    set_op(0, 8'h0F, 8'hFF);
    req = 4'b0101;
    #1;
    chk("wrap_g0", 32'(gnt), 32'b0001);
    tick();
    chk("wrap_g2", 32'(gnt), 32'b0100);
    tick();
    req = 4'b0000;
    #1;
    chk_q("wrap_r0", 8'h0F, 2'd0);
    tick();
    chk_q("wrap_r2", 8'h30, 2'd2);
    tick();
    chk("wrap_qv_off", 32'(q_valid), 32'h0);

    // Hold: ptr=3, issue 3 then 0, freeze two cycles, resume with 1.
    for (int i = 0; i < N; i++) set_op(i, 8'hFF, 8'(8'h11 * (i + 1)));
    req = 4'b1111;
    #1;
    chk("hold_g3", 32'(gnt), 32'b1000);
    tick();
    chk("hold_g0", 32'(gnt), 32'b0001);
    chk("hold_qv_pre", 32'(q_valid), 32'h0);
    tick();
    hold = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("hold_gnt", 32'(gnt), 32'h0);
      chk_q("hold_frozen", 8'h44, 2'd3);
      tick();
    end
    hold = 1'b0;
    #1;
    chk("hold_resume_g1", 32'(gnt), 32'b0010);
    chk_q("hold_acc0", 8'h44, 2'd3);
    tick();
    req = 4'b0000;
    #1;
    chk_q("hold_acc1", 8'h11, 2'd0);
    tick();
    chk_q("hold_acc2", 8'h22, 2'd1);
    tick();
    chk("hold_drain_qv", 32'(q_valid), 32'h0);

    // Reset mid-flight with both stages valid.
    req = 4'b1111;
    #1;
    chk("mid_g2", 32'(gnt), 32'b0100);
    tick();
    chk("mid_g3", 32'(gnt), 32'b1000);
    tick();
    chk_q("mid_pre", 8'h33, 2'd2);
    chk("mid_pre_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    req = 4'b0000;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    tick();
    reset = 1'b0;
    req = 4'b1111;
    #1;
    chk("mid_qv", 32'(q_valid), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_ptr0", 32'(gnt), 32'b0001);
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("mid_no_ghost", 32'(q_valid), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
